// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of arbitrary depth with valid/ready handshakes
// on both sides, programmable almost-full/almost-empty flags, a synchronous
// flush and a high-water-mark monitor of the peak occupancy.
module sync_fifo #(
  parameter int ELEM_WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  flush_i,
  input  logic [ELEM_WIDTH-1:0] elem_in_i,
  input  logic                  elem_in_valid_i,
  output logic                  elem_in_ready_o,
  output logic [ELEM_WIDTH-1:0] elem_out_o,
  output logic                  elem_out_valid_o,
  input  logic                  elem_out_ready_i,
  output logic [CW-1:0]         count_o,
  input  logic [CW-1:0]         almost_full_th_i,
  input  logic [CW-1:0]         almost_empty_th_i,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CW-1:0]         hwm_o
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);

  logic [ELEM_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr_next;
  logic [AW-1:0]         rd_ptr_next;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [CW-1:0]         hwm;
  logic                  push;
  logic                  pop;

  // Handshake qualifiers are gated by reset and flush so that neither side
  // ever sees a transfer while state is being discarded.
  assign elem_in_ready_o  = !srst_i && !flush_i && (count != FULL_COUNT);
  assign elem_out_valid_o = !srst_i && !flush_i && (count != '0);
  assign push             = elem_in_valid_i && elem_in_ready_o;
  assign pop              = elem_out_valid_o && elem_out_ready_i;

  assign elem_out_o     = mem[rd_ptr];
  assign count_o        = count;
  assign hwm_o          = hwm;
  assign almost_full_o  = (count >= almost_full_th_i);
  assign almost_empty_o = (count <= almost_empty_th_i);

  // Next pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work,
  // and the occupancy moves only when exactly one side transfers.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (push) begin
      wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
    end
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // Control state: reset and flush both clear everything, otherwise the
  // high-water mark tracks the largest occupancy that will be reached.
  always_ff @(posedge clk_i) begin
    if (srst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hwm    <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      hwm    <= (count_next > hwm) ? count_next : hwm;
    end
  end

  // Storage is written on an accepted push and is never cleared.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= elem_in_i;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed and randomized stimulus for sync_fifo (DEPTH 5),
// compared every cycle against a queue-based reference model.
module tb_sync_fifo;

  localparam int W = 8;
  localparam int D = 5;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          srst;
  logic          flush;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [CW-1:0] count;
  logic [CW-1:0] af_th;
  logic [CW-1:0] ae_th;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] hwm;

  int total = 0;
  int bad = 0;

  logic [W-1:0] model_q[$];
  int           model_hwm = 0;

  sync_fifo #(.ELEM_WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk),
    .srst_i(srst),
    .flush_i(flush),
    .elem_in_i(din),
    .elem_in_valid_i(din_valid),
    .elem_in_ready_o(din_ready),
    .elem_out_o(dout),
    .elem_out_valid_o(dout_valid),
    .elem_out_ready_i(dout_ready),
    .count_o(count),
    .almost_full_th_i(af_th),
    .almost_empty_th_i(ae_th),
    .almost_full_o(almost_full),
    .almost_empty_o(almost_empty),
    .hwm_o(hwm)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, checks all outputs against the model before
  // the edge, then advances the model by the rules of the FIFO.
  task automatic applyStimulus(input logic rst, input logic fl, input logic vin,
                               input logic [W-1:0] data, input logic rin);
    bit exp_ready;
    bit exp_valid;
    int occ;
    srst       = rst;
    flush      = fl;
    din_valid  = vin;
    din        = data;
    dout_ready = rin;
    #1;
    occ       = model_q.size();
    exp_ready = !rst && !fl && (occ != D);
    exp_valid = !rst && !fl && (occ != 0);
    checkOutput("ready", 32'(din_ready), 32'(exp_ready));
    checkOutput("valid", 32'(dout_valid), 32'(exp_valid));
    checkOutput("count", 32'(count), 32'(occ));
    checkOutput("hwm", 32'(hwm), 32'(model_hwm));
    checkOutput("almost_full", 32'(almost_full), 32'(occ >= int'(af_th)));
    checkOutput("almost_empty", 32'(almost_empty), 32'(occ <= int'(ae_th)));
    if (exp_valid) begin
      checkOutput("data", 32'(dout), 32'(model_q[0]));
    end
    @(posedge clk);
    if (rst || fl) begin
      model_q.delete();
      model_hwm = 0;
    end else begin
      if (rin && exp_valid) void'(model_q.pop_front());
      if (vin && exp_ready) model_q.push_back(data);
      if (model_q.size() > model_hwm) model_hwm = model_q.size();
    end
    #1;
  endtask

  initial begin
    srst = 1'b1; flush = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    af_th = CW'(4); ae_th = CW'(1);
    @(posedge clk);
    #1;

    // Reset held for three checked cycles, then idle.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);

    // Fill with 0x10..0x14, then one extra push that must be refused.
    for (int i = 0; i < D; i++) applyStimulus(0, 0, 1, W'(8'h10 + i), 0);
    applyStimulus(0, 0, 1, 8'h99, 0);
    // Drain everything in order.
    for (int i = 0; i < D + 1; i++) applyStimulus(0, 0, 0, 8'h00, 1);

    // Twelve more elements pushed in bursts of three and drained, crossing the wrap.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, W'(8'h20 + b * 3 + i), 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00, 1);
    end

    // Streaming at occupancy 2 with both sides active every cycle.
    applyStimulus(0, 0, 1, 8'h40, 0);
    applyStimulus(0, 0, 1, 8'h41, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, W'(8'h50 + i), 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00, 1);

    // Flush with input valid high, after peak of three and one pop.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, W'(8'h70 + i), 0);
    applyStimulus(0, 0, 0, 8'h00, 1);
    applyStimulus(0, 1, 1, 8'hEE, 1);
    applyStimulus(0, 0, 1, 8'h80, 0);
    applyStimulus(0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 8'h00, 0);

    // Reset mid-operation with a push in progress.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, W'(8'h90 + i), 0);
    applyStimulus(1, 0, 1, 8'h93, 0);
    applyStimulus(0, 0, 1, 8'hA0, 0);
    applyStimulus(0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 8'h00, 0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 2) != 0);
    end

    // Extreme thresholds: almost_full always set, almost_empty always set.
    af_th = '0; ae_th = CW'(D);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 0, $urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
